// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default bit timing.
// The transmitter uses the same package.
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int CLKS_PER_BIT_DEF = 5208;  // 50 MHz / 9600 baud

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous board inputs; INIT sets the reset level.
module uart_sync2 #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= INIT;
            q    <= INIT;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1 LSB first, idle-high line; define UART_RX_PARITY_EN for 8E1
// framing with an extra parity_err strobe.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] data,
    output logic                   valid,
    output logic                   busy,
    output logic                   frame_err
`ifdef UART_RX_PARITY_EN
   ,output logic                   parity_err
`endif
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t            state;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             idx;
    logic [UART_DATA_W-1:0] shreg;
    logic                   rx_s;
    logic                   rx_prev;
`ifdef UART_RX_PARITY_EN
    logic                   par_fail;
`endif

    uart_sync2 #(.INIT(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            rx_prev   <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_fail   <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_prev   <= rx_s;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // Edge-triggered so a held-low (break) line cannot retrigger
                    if (rx_prev && !rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[UART_DATA_W-1:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL) begin
                        cnt      <= '0;
                        par_fail <= ^{shreg, rx_s};
                        state    <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    // Leaves at mid-stop-bit so a back-to-back start edge is caught
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_fail) begin
                            parity_err <= 1'b1;
`endif
                        end else begin
                            data  <= shreg;
                            valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
